// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module  : load_store_unit
// Purpose : Multi-cycle byte/half/word load-store unit with read-modify-write
//           for sub-word stores and a single-port data memory interface.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    localparam logic [31:0] C_MEM_WORDS = MEM_WORDS[31:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic [15:0] r_sdata;
    logic        r_req_err;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic [31:0] r_load_data;
    logic        r_err;
    logic        r_resp_valid;

    logic        w_f3_ld_ok;
    logic        w_f3_st_ok;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;
    logic [31:0] w_merge;

    // Request legality, evaluated on the raw inputs at accept time
    always_comb begin
        w_f3_ld_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
        w_f3_st_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        w_oor      = ({2'b00, addr[31:2]} >= C_MEM_WORDS);
        w_err      = w_misalign || w_oor || (req_write ? !w_f3_st_ok : !w_f3_ld_ok);
    end

    always_comb begin
        w_byte = MemReadData[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = MemReadData[7:0];
            2'd1: w_byte = MemReadData[15:8];
            2'd2: w_byte = MemReadData[23:16];
            2'd3: w_byte = MemReadData[31:24];
            default: w_byte = MemReadData[7:0];
        endcase
        w_half = r_addr[1] ? MemReadData[31:16] : MemReadData[15:0];

        w_fmt = MemReadData;
        case (r_funct3)
            3'b000: w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001: w_fmt = {{16{w_half[15]}}, w_half};
            3'b100: w_fmt = {24'd0, w_byte};
            3'b101: w_fmt = {16'd0, w_half};
            default: w_fmt = MemReadData;
        endcase

        // Sub-word store: only the addressed lane changes
        w_merge = MemReadData;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'd0: w_merge[7:0]   = r_sdata[7:0];
                2'd1: w_merge[15:8]  = r_sdata[7:0];
                2'd2: w_merge[23:16] = r_sdata[7:0];
                2'd3: w_merge[31:24] = r_sdata[7:0];
                default: w_merge = MemReadData;
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_sdata;
        end else begin
            w_merge[15:0] = r_sdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err)                  w_next = S_RESP;
                    else if (!req_write)        w_next = S_RD;
                    else if (funct3 == 3'b010)  w_next = S_WR;
                    else                        w_next = S_RD;
                end
            end
            S_RD:    w_next = r_write ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= 32'd0;
            r_funct3     <= 3'd0;
            r_write      <= 1'b0;
            r_sdata      <= 16'd0;
            r_req_err    <= 1'b0;
            r_merge      <= 32'd0;
            r_rdata      <= 32'd0;
            r_load_data  <= 32'd0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr    <= addr;
                        r_funct3  <= funct3;
                        r_write   <= req_write;
                        r_sdata   <= store_data[15:0];
                        r_req_err <= w_err;
                        r_rdata   <= 32'd0;
                        // A full-word store needs no read, so its data is the merge result
                        r_merge   <= (req_write && (funct3 == 3'b010)) ? store_data : 32'd0;
                    end
                end
                S_RD: begin
                    if (r_write) r_merge <= w_merge;
                    else         r_rdata <= w_fmt;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b1;
                    r_err        <= r_req_err;
                    r_load_data  <= (!r_write && !r_req_err) ? r_rdata : 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = r_resp_valid;
    assign err          = r_err;
    assign load_data    = r_load_data;
    assign MemAddr      = {r_addr[31:2], 2'b00};
    assign MemRead      = (r_state == S_RD);
    assign MemWrite     = (r_state == S_WR) && !reset;
    assign MemWriteData = (r_state == S_WR) ? r_merge : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_load_store_unit
// Purpose : Scoreboard bench for load_store_unit with a behavioural memory.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        err;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .load_data(load_data),
        .err(err), .MemAddr(MemAddr), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:31];
    assign MemReadData = mem[MemAddr[6:2]];

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] last_wdata = 32'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MemWrite) begin
            mem[MemAddr[6:2]] <= MemWriteData;
            last_wdata <= MemWriteData;
            wr_cnt <= wr_cnt + 1;
        end
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (!reset && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    // Response monitor: every resp_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: resp_valid=1 with no outstanding request at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if (err !== e.err) $display("FAIL resp_err: got %0b expected %0b", err, e.err);
                else n_pass++;
                n_checks++;
                if (load_data !== e.data) $display("FAIL resp_data: got %h expected %h", load_data, e.data);
                else n_pass++;
                n_checks++;
                if ((cyc - e.acc) !== e.lat) $display("FAIL resp_latency: got %0d expected %0d", cyc - e.acc, e.lat);
                else n_pass++;
            end
        end
    end

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic e_err, input logic [31:0] e_data,
                          input int e_lat);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!req_ready) $display("FAIL req_ready_timeout: got %0b expected 1", req_ready);
        else n_pass++;
        req_valid  = 1'b1;
        req_write  = w;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        e.err = e_err; e.data = e_data; e.lat = e_lat; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", req_ready);
        else n_pass++;
        n_checks++;
        if ({resp_valid, err, MemWrite, MemRead} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {resp_valid, err, MemWrite, MemRead});
        else n_pass++;
        n_checks++;
        if ({load_data, MemAddr, MemWriteData} !== 96'd0)
            $display("FAIL reset_data: got %h expected 0", {load_data, MemAddr, MemWriteData});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [31:0] held;
        mem[1] = 32'h8899AABB;
        do_req(1'b0, 3'b000, 32'd4, 32'd0, 1'b0, 32'hFFFFFFBB, 2); wait_drain();
        do_req(1'b0, 3'b101, 32'd6, 32'd0, 1'b0, 32'h00008899, 2); wait_drain();
        do_req(1'b0, 3'b001, 32'd6, 32'd0, 1'b0, 32'hFFFF8899, 2); wait_drain();
        do_req(1'b0, 3'b100, 32'd7, 32'd0, 1'b0, 32'h00000088, 2); wait_drain();
        do_req(1'b0, 3'b001, 32'd4, 32'd0, 1'b0, 32'hFFFFAABB, 2); wait_drain();
        do_req(1'b0, 3'b010, 32'd4, 32'd0, 1'b0, 32'h8899AABB, 2); wait_drain();
        held = 32'h8899AABB;
        repeat (3) @(negedge clk);
        n_checks++;
        if (load_data !== held) $display("FAIL load_hold: got %h expected %h", load_data, held);
        else n_pass++;
    endtask

    task automatic test_stores();
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 3'b000, 32'd5, 32'h12345677, 1'b0, 32'd0, 3); wait_drain();
        n_checks++;
        if ((rd_cnt - rd0) !== 1 || (wr_cnt - wr0) !== 1)
            $display("FAIL sb_strobes: got rd=%0d wr=%0d expected rd=1 wr=1", rd_cnt - rd0, wr_cnt - wr0);
        else n_pass++;
        n_checks++;
        if (last_wdata !== 32'h889977BB) $display("FAIL sb_wdata: got %h expected 889977bb", last_wdata);
        else n_pass++;
        do_req(1'b0, 3'b010, 32'd4, 32'd0, 1'b0, 32'h889977BB, 2); wait_drain();

        mem[0] = 32'h11223344;
        do_req(1'b1, 3'b001, 32'd2, 32'h0000BEEF, 1'b0, 32'd0, 3); wait_drain();
        do_req(1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'hBEEF3344, 2); wait_drain();

        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 3'b010, 32'd8, 32'hCAFEBABE, 1'b0, 32'd0, 2); wait_drain();
        n_checks++;
        if ((rd_cnt - rd0) !== 0 || (wr_cnt - wr0) !== 1 || last_wdata !== 32'hCAFEBABE)
            $display("FAIL sw_write: got rd=%0d wr=%0d data=%h expected rd=0 wr=1 data=cafebabe",
                     rd_cnt - rd0, wr_cnt - wr0, last_wdata);
        else n_pass++;
    endtask

    task automatic test_errors();
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 3'b010, 32'd2,   32'd0, 1'b1, 32'd0, 1); wait_drain();
        do_req(1'b1, 3'b010, 32'd128, 32'h5555AAAA, 1'b1, 32'd0, 1); wait_drain();
        do_req(1'b0, 3'b001, 32'd1,   32'd0, 1'b1, 32'd0, 1); wait_drain();
        do_req(1'b0, 3'b011, 32'd0,   32'd0, 1'b1, 32'd0, 1); wait_drain();
        do_req(1'b1, 3'b100, 32'd0,   32'd0, 1'b1, 32'd0, 1); wait_drain();
        do_req(1'b0, 3'b100, 32'd127, 32'd0, 1'b0, 32'd0, 2); wait_drain();
        n_checks++;
        if ((rd_cnt - rd0) !== 1 || (wr_cnt - wr0) !== 0)
            $display("FAIL err_no_access: got rd=%0d wr=%0d expected rd=1 wr=0", rd_cnt - rd0, wr_cnt - wr0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int wr0;
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'd0; store_data = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0) $display("FAIL rst_wr_gate: got MemWrite=%0b expected 0", MemWrite);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL rst_wr_state: got ready=%0b resp=%0b expected ready=1 resp=0", req_ready, resp_valid);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if (mem[0] !== 32'hBEEF3344 || (wr_cnt - wr0) !== 0)
            $display("FAIL rst_wr_mem: got %h writes=%0d expected beef3344 writes=0", mem[0], wr_cnt - wr0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   acc0, rv0;
        acc0 = acc_cnt; rv0 = rv_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'd8; store_data = 32'd0;
        e.err = 1'b0; e.data = 32'hCAFEBABE; e.lat = 2; e.acc = cyc + 1;
        sb.push_back(e);
        e.acc = cyc + 4;
        sb.push_back(e);
        repeat (4) @(negedge clk);
        req_valid = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        n_checks++;
        if ((acc_cnt - acc0) !== 2) $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt - acc0);
        else n_pass++;
        n_checks++;
        if ((rv_cnt - rv0) !== 2) $display("FAIL b2b_resp_cycles: got %0d expected 2", rv_cnt - rv0);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
